rng_word_packer: RTL and testbench

Downstream consumer of the LFSR PRBS stream generator in the TPM RNG path. It pulls narrow chunks from the generator by driving the generator's `enable`, and runs a repetition-count health test on every chunk. It packs accepted chunks LSB-first into wide words and buffers the words in a small first-word-fall-through FIFO. The TPM register/command logic drains the FIFO through a valid/ready handshake.

---
 rtl/rng_word_packer.sv | 83 ++++++++
 tb/tb_rng_word_packer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/rng_word_packer.sv
// rng_word_packer: packs health-tested RNG chunks LSB-first into words buffered in a FWFT FIFO
module rng_word_packer #(
  parameter int IN_WIDTH   = 8,
  parameter int OUT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int REP_LIMIT  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic                              rng_enable,
  input  logic [IN_WIDTH-1:0]               rng_data,
  output logic [OUT_WIDTH-1:0]              m_data,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              health_fail
);
  localparam int RATIO = OUT_WIDTH / IN_WIDTH;
  localparam int IW = RATIO > 1 ? $clog2(RATIO) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int RW = $clog2(REP_LIMIT + 1);
  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [OUT_WIDTH-1:0] partial, word;
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level;
  logic [IW-1:0]        idx;
  logic [IN_WIDTH-1:0]  prev;
  logic                 have_prev;
  logic [RW-1:0]        rep_cnt, rep_next;
  logic                 sample, trip, last, push, pop;
  assign rng_enable = !health_fail && level < LW'(FIFO_DEPTH);
  assign m_valid    = !health_fail && level != '0;
  assign m_data     = m_valid ? mem[rd_ptr] : '0;
  assign fifo_level = level;
  assign sample     = rng_enable;
  assign rep_next   = (have_prev && prev == rng_data) ? rep_cnt + 1'b1 : RW'(1);
  assign trip       = sample && rep_next == RW'(REP_LIMIT);
  assign last       = idx == IW'(RATIO - 1);
  assign push       = sample && !trip && last;
  assign pop        = m_valid && m_ready;
  always_comb begin
    word = partial;
    word[idx*IN_WIDTH +: IN_WIDTH] = rng_data;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= word;
  // a tripping chunk flushes everything; the repetition history still advances
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      health_fail <= 1'b0;
      level       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      idx         <= '0;
      partial     <= '0;
      prev        <= '0;
      have_prev   <= 1'b0;
      rep_cnt     <= '0;
    end else begin
      if (trip) begin
        health_fail <= 1'b1;
        level       <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        idx         <= '0;
        partial     <= '0;
      end else begin
        if (sample) begin
          idx     <= last ? '0 : idx + 1'b1;
          partial <= word;
        end
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push != pop) level <= push ? level + 1'b1 : level - 1'b1;
      end
      if (sample) begin
        prev      <= rng_data;
        have_prev <= 1'b1;
        rep_cnt   <= rep_next;
      end
    end
endmodule

// File: tb/tb_rng_word_packer.sv
// tb_rng_word_packer: directed scoreboard bench for rng_word_packer
module tb_rng_word_packer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rng_enable;
  logic [7:0]  rng_data, drv_data = 8'h00, gen_cnt = 8'h00;
  logic        gen_on = 1'b0;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [2:0]  fifo_level;
  logic        health_fail;
  int          checks = 0, errors = 0;
  logic [31:0] exp_q [$];
  rng_word_packer dut (
    .clk(clk), .rst(rst), .rng_enable(rng_enable), .rng_data(rng_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_level(fifo_level), .health_fail(health_fail)
  );
  always #5 clk = ~clk;
  assign rng_data = gen_on ? gen_cnt : drv_data;
  // stand-in generator: a counter that advances only when its chunk is consumed
  always @(posedge clk)
    if (!rst && gen_on && rng_enable) gen_cnt <= gen_cnt + 8'd1;
  always @(negedge clk)
    if (!rst && m_valid && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %h, required no word", m_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (m_data !== e) begin
          errors++;
          $display("FAIL pop_data: got %h, required %h", m_data, e);
        end
      end
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chunk(input logic [7:0] d);
    drv_data = d;
    tick();
  endtask
  task automatic reset_hold();
    rst = 1'b1;
    #1;
    chk("rst_valid", {31'b0, m_valid}, 0);
    chk("rst_level", {29'b0, fifo_level}, 0);
    chk("rst_fail", {31'b0, health_fail}, 0);
    chk("rst_enable", {31'b0, rng_enable}, 1);
    tick();
  endtask
  task automatic drain();
    gen_on = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 10 && fifo_level != 0; i++) tick();
    m_ready = 1'b0;
    gen_on = 1'b0;
    chk("drain_level", {29'b0, fifo_level}, 0);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end
  initial begin
    tick();
    reset_hold();
    rst = 1'b0;
    chunk(8'h01); chunk(8'h02); chunk(8'h03);
    chk("pack_valid_early", {31'b0, m_valid}, 0);
    chunk(8'h04);
    chk("pack_valid", {31'b0, m_valid}, 1);
    chk("pack_level", {29'b0, fifo_level}, 1);
    chk("pack_data", m_data, 32'h04030201);
    chunk(8'h21); chunk(8'h22);
    reset_hold();
    rst = 1'b0;
    exp_q.push_back(32'h34333231);
    chunk(8'h31); chunk(8'h32); chunk(8'h33); chunk(8'h34);
    chk("post_rst_level", {29'b0, fifo_level}, 1);
    drain();
    reset_hold();
    gen_cnt = 8'h40;
    gen_on = 1'b1;
    exp_q.push_back(32'h43424140);
    exp_q.push_back(32'h47464544);
    exp_q.push_back(32'h4b4a4948);
    exp_q.push_back(32'h4f4e4d4c);
    exp_q.push_back(32'h53525150);
    rst = 1'b0;
    repeat (16) tick();
    chk("full_level", {29'b0, fifo_level}, 4);
    chk("full_enable", {31'b0, rng_enable}, 0);
    chk("full_gen", {24'b0, gen_cnt}, 32'h50);
    repeat (10) tick();
    chk("hold_gen", {24'b0, gen_cnt}, 32'h50);
    chk("hold_head", m_data, 32'h43424140);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("pop_level", {29'b0, fifo_level}, 3);
    chk("pop_enable", {31'b0, rng_enable}, 1);
    repeat (4) tick();
    chk("refill_level", {29'b0, fifo_level}, 4);
    chk("refill_enable", {31'b0, rng_enable}, 0);
    drain();
    reset_hold();
    rst = 1'b0;
    chunk(8'h11); chunk(8'h12); chunk(8'h13); chunk(8'h14);
    chunk(8'hAA); chunk(8'hAA); chunk(8'hAA);
    chk("hf_pre_fail", {31'b0, health_fail}, 0);
    chk("hf_pre_level", {29'b0, fifo_level}, 1);
    chunk(8'hAA);
    chk("hf_fail", {31'b0, health_fail}, 1);
    chk("hf_level", {29'b0, fifo_level}, 0);
    chk("hf_valid", {31'b0, m_valid}, 0);
    chk("hf_enable", {31'b0, rng_enable}, 0);
    m_ready = 1'b1;
    drv_data = 8'h5C;
    repeat (5) tick();
    m_ready = 1'b0;
    chk("hf_sticky", {31'b0, health_fail}, 1);
    chk("hf_sticky_valid", {31'b0, m_valid}, 0);
    reset_hold();
    rst = 1'b0;
    chunk(8'h01); chunk(8'h02); chunk(8'h03); chunk(8'hAA);
    chk("cross_level", {29'b0, fifo_level}, 1);
    chunk(8'hAA); chunk(8'hAA);
    chk("cross_pre_fail", {31'b0, health_fail}, 0);
    chunk(8'hAA);
    chk("cross_fail", {31'b0, health_fail}, 1);
    chk("cross_flush", {29'b0, fifo_level}, 0);
    reset_hold();
    rst = 1'b0;
    exp_q.push_back(32'h55AAAAAA);
    exp_q.push_back(32'h55AAAAAA);
    chunk(8'hAA); chunk(8'hAA); chunk(8'hAA); chunk(8'h55);
    chunk(8'hAA); chunk(8'hAA); chunk(8'hAA); chunk(8'h55);
    chk("near_fail", {31'b0, health_fail}, 0);
    chk("near_level", {29'b0, fifo_level}, 2);
    chk("near_head", m_data, 32'h55AAAAAA);
    drain();
    reset_hold();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
